// File: rtl/axi_ic_pkg.sv
// Shared interconnect definitions: arbiter state encoding and master-count limit.
package axi_ic_pkg;

   localparam int MAX_NUM_M = 4;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_ADDR = 2'd1,
      ARB_WAIT = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first requester found scanning upward
// from last_grant_i+1, wrapping at NUM_M.
module rr_priority_picker #(
   parameter int NUM_M = 2,
   parameter int IDX_W = 2
) (
   input  logic [NUM_M-1:0] req_i,
   input  logic [IDX_W-1:0] last_grant_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             found_o
);

   localparam int SLOTS = 1 << IDX_W;

   // Padding to a power of two lets the candidate index select without width games.
   logic [SLOTS-1:0] req_pad;
   logic [IDX_W-1:0] cand;
   int               cand_int;

   always_comb begin
      req_pad              = '0;
      req_pad[NUM_M-1:0]   = req_i;
      idx_o                = '0;
      found_o              = 1'b0;
      cand_int             = 0;
      cand                 = '0;
      for (int k = 1; k <= NUM_M; k++) begin
         cand_int = (int'(last_grant_i) + k) % NUM_M;
         cand     = cand_int[IDX_W-1:0];
         if (!found_o && req_pad[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/axi_addr_rr_arbiter.sv
// Round-robin owner of a shared AXI address channel; the grant is held from
// address issue until the transaction's response completes (Txn_Done).
module axi_addr_rr_arbiter
   import axi_ic_pkg::*;
#(
   parameter int NUM_M  = 2,
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 8,
   parameter int IDX_W  = 2
) (
   input  logic                    ACLK,
   input  logic                    ARESETN,
   input  logic [NUM_M-1:0]        M_AxVALID,
   input  logic [NUM_M*ADDR_W-1:0] M_AxADDR,
   input  logic [NUM_M*LEN_W-1:0]  M_AxLEN,
   output logic [NUM_M-1:0]        M_AxREADY,
   output logic                    S_AxVALID,
   output logic [ADDR_W-1:0]       S_AxADDR,
   output logic [LEN_W-1:0]        S_AxLEN,
   input  logic                    S_AxREADY,
   input  logic                    Txn_Done,
   output logic [IDX_W-1:0]        Grant_Idx,
   output logic [NUM_M-1:0]        Grant_Onehot,
   output logic                    Busy
);

   localparam int SLOTS = 1 << IDX_W;

   arb_state_e       state_q;
   logic [IDX_W-1:0] grant_idx_q;
   logic [IDX_W-1:0] last_grant_q;
   logic [NUM_M-1:0] grant_oh_q;
   logic [NUM_M-1:0] grant_oh_d;
   logic             busy_q;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_found;

   logic [SLOTS-1:0]  vld_pad;
   logic [ADDR_W-1:0] addr_arr [SLOTS];
   logic [LEN_W-1:0]  len_arr  [SLOTS];

   // Unpack per-master fields; unused slots read as zero.
   generate
      for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
         if (gi < NUM_M) begin : g_real
            assign vld_pad[gi]  = M_AxVALID[gi];
            assign addr_arr[gi] = M_AxADDR[gi*ADDR_W +: ADDR_W];
            assign len_arr[gi]  = M_AxLEN[gi*LEN_W +: LEN_W];
         end else begin : g_pad
            assign vld_pad[gi]  = 1'b0;
            assign addr_arr[gi] = '0;
            assign len_arr[gi]  = '0;
         end
      end
      for (genvar gi = 0; gi < NUM_M; gi++) begin : g_ready
         assign M_AxREADY[gi] = (state_q == ARB_ADDR) && grant_oh_q[gi] && S_AxREADY;
      end
   endgenerate

   rr_priority_picker #(
      .NUM_M (NUM_M),
      .IDX_W (IDX_W)
   ) u_picker (
      .req_i        (M_AxVALID),
      .last_grant_i (last_grant_q),
      .idx_o        (pick_idx),
      .found_o      (pick_found)
   );

   assign grant_oh_d   = NUM_M'(1) << pick_idx;
   assign S_AxVALID    = (state_q == ARB_ADDR) && vld_pad[grant_idx_q];
   assign S_AxADDR     = busy_q ? addr_arr[grant_idx_q] : '0;
   assign S_AxLEN      = busy_q ? len_arr[grant_idx_q]  : '0;
   assign Grant_Idx    = grant_idx_q;
   assign Grant_Onehot = grant_oh_q;
   assign Busy         = busy_q;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q      <= ARB_IDLE;
         grant_idx_q  <= '0;
         grant_oh_q   <= '0;
         busy_q       <= 1'b0;
         last_grant_q <= IDX_W'(NUM_M - 1);
      end else begin
         case (state_q)
            ARB_IDLE: begin
               if (pick_found) begin
                  grant_idx_q <= pick_idx;
                  grant_oh_q  <= grant_oh_d;
                  busy_q      <= 1'b1;
                  state_q     <= ARB_ADDR;
               end
            end
            ARB_ADDR: begin
               if (S_AxVALID && S_AxREADY) state_q <= ARB_WAIT;
            end
            ARB_WAIT: begin
               if (Txn_Done) begin
                  last_grant_q <= grant_idx_q;
                  grant_oh_q   <= '0;
                  busy_q       <= 1'b0;
                  state_q      <= ARB_IDLE;
               end
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_addr_rr_arbiter.sv
// Directed bench for the round-robin address arbiter (three masters).
module tb_axi_addr_rr_arbiter;

   localparam int NUM_M  = 3;
   localparam int ADDR_W = 32;
   localparam int LEN_W  = 8;
   localparam int IDX_W  = 2;

   logic                    ACLK = 1'b0;
   logic                    ARESETN = 1'b0;
   logic [NUM_M-1:0]        M_AxVALID = '0;
   logic [NUM_M*ADDR_W-1:0] M_AxADDR;
   logic [NUM_M*LEN_W-1:0]  M_AxLEN;
   logic [NUM_M-1:0]        M_AxREADY;
   logic                    S_AxVALID;
   logic [ADDR_W-1:0]       S_AxADDR;
   logic [LEN_W-1:0]        S_AxLEN;
   logic                    S_AxREADY = 1'b0;
   logic                    Txn_Done = 1'b0;
   logic [IDX_W-1:0]        Grant_Idx;
   logic [NUM_M-1:0]        Grant_Onehot;
   logic                    Busy;

   logic [ADDR_W-1:0] addr_v [NUM_M];
   logic [LEN_W-1:0]  len_v  [NUM_M];

   assign M_AxADDR = {addr_v[2], addr_v[1], addr_v[0]};
   assign M_AxLEN  = {len_v[2], len_v[1], len_v[0]};

   always #5 ACLK = ~ACLK;

   axi_addr_rr_arbiter #(
      .NUM_M  (NUM_M),
      .ADDR_W (ADDR_W),
      .LEN_W  (LEN_W),
      .IDX_W  (IDX_W)
   ) dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .M_AxVALID    (M_AxVALID),
      .M_AxADDR     (M_AxADDR),
      .M_AxLEN      (M_AxLEN),
      .M_AxREADY    (M_AxREADY),
      .S_AxVALID    (S_AxVALID),
      .S_AxADDR     (S_AxADDR),
      .S_AxLEN      (S_AxLEN),
      .S_AxREADY    (S_AxREADY),
      .Txn_Done     (Txn_Done),
      .Grant_Idx    (Grant_Idx),
      .Grant_Onehot (Grant_Onehot),
      .Busy         (Busy)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic nxt();
      @(posedge ACLK);
      #1;
   endtask

   task automatic do_reset();
      ARESETN   = 1'b0;
      M_AxVALID = '0;
      S_AxREADY = 1'b0;
      Txn_Done  = 1'b0;
      repeat (2) nxt();
      ARESETN = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      addr_v[0] = 32'h0000_0A00; len_v[0] = 8'd0;
      addr_v[1] = 32'h0000_1000; len_v[1] = 8'd3;
      addr_v[2] = 32'h0000_2C00; len_v[2] = 8'd7;

      // Reset state
      #12;
      chk("rst_busy",   64'(Busy), 64'd0);
      chk("rst_oh",     64'(Grant_Onehot), 64'd0);
      chk("rst_idx",    64'(Grant_Idx), 64'd0);
      chk("rst_svalid", 64'(S_AxVALID), 64'd0);
      chk("rst_mready", 64'(M_AxREADY), 64'd0);
      chk("rst_saddr",  64'(S_AxADDR), 64'd0);
      chk("rst_slen",   64'(S_AxLEN), 64'd0);
      nxt();
      ARESETN = 1'b1;
      nxt();

      // Single request from master 1
      M_AxVALID = 3'b010;
      S_AxREADY = 1'b1;
      nxt();
      chk("single_idx",    64'(Grant_Idx), 64'd1);
      chk("single_oh",     64'(Grant_Onehot), 64'b010);
      chk("single_busy",   64'(Busy), 64'd1);
      chk("single_svalid", 64'(S_AxVALID), 64'd1);
      chk("single_saddr",  64'(S_AxADDR), 64'h1000);
      chk("single_slen",   64'(S_AxLEN), 64'd3);
      chk("single_mready", 64'(M_AxREADY), 64'b010);
      $display("txn single: grant=%0d addr=%h len=%0d", Grant_Idx, S_AxADDR, S_AxLEN);
      nxt();
      M_AxVALID = '0;
      #1;
      chk("single_wait_mready", 64'(M_AxREADY), 64'd0);
      chk("single_wait_svalid", 64'(S_AxVALID), 64'd0);
      chk("single_wait_busy",   64'(Busy), 64'd1);
      chk("single_wait_saddr",  64'(S_AxADDR), 64'h1000);
      Txn_Done = 1'b1;
      nxt();
      Txn_Done = 1'b0;
      chk("single_done_busy", 64'(Busy), 64'd0);
      chk("single_done_oh",   64'(Grant_Onehot), 64'd0);
      S_AxREADY = 1'b0;

      // Contention fairness: all three requesting
      do_reset();
      M_AxVALID = 3'b111;
      for (int k = 0; k < 6; k++) begin
         for (int w = 0; w < 8 && S_AxVALID !== 1'b1; w++) nxt();
         chk("fair_svalid", 64'(S_AxVALID), 64'd1);
         chk("fair_idx",    64'(Grant_Idx), 64'(k % NUM_M));
         chk("fair_saddr",  64'(S_AxADDR), 64'(addr_v[k % NUM_M]));
         chk("fair_noready", 64'(M_AxREADY), 64'd0);
         $display("txn fair %0d: grant=%0d addr=%h", k, Grant_Idx, S_AxADDR);
         nxt();
         S_AxREADY = 1'b1;
         #1;
         chk("fair_mready", 64'(M_AxREADY), 64'(3'b001 << (k % NUM_M)));
         nxt();
         S_AxREADY = 1'b0;
         repeat (3) nxt();
         Txn_Done = 1'b1;
         nxt();
         Txn_Done = 1'b0;
      end

      // Hold-off of master 1 while master 0 waits for its response
      do_reset();
      M_AxVALID = 3'b001;
      S_AxREADY = 1'b1;
      nxt();
      chk("hold_first_idx", 64'(Grant_Idx), 64'd0);
      $display("txn hold a: grant=%0d addr=%h", Grant_Idx, S_AxADDR);
      nxt();
      M_AxVALID = 3'b010;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("hold_mready", 64'(M_AxREADY), 64'd0);
         chk("hold_idx",    64'(Grant_Idx), 64'd0);
         chk("hold_busy",   64'(Busy), 64'd1);
         nxt();
      end
      Txn_Done = 1'b1;
      nxt();
      Txn_Done = 1'b0;
      chk("hold_idle_busy", 64'(Busy), 64'd0);
      nxt();
      chk("hold_second_idx",    64'(Grant_Idx), 64'd1);
      chk("hold_second_oh",     64'(Grant_Onehot), 64'b010);
      chk("hold_second_svalid", 64'(S_AxVALID), 64'd1);
      $display("txn hold b: grant=%0d addr=%h", Grant_Idx, S_AxADDR);
      nxt();
      M_AxVALID = '0;
      Txn_Done  = 1'b1;
      nxt();
      Txn_Done  = 1'b0;
      S_AxREADY = 1'b0;

      // Slave backpressure with a spurious Txn_Done mid-stall
      M_AxVALID = 3'b100;
      nxt();
      for (int i = 0; i < 5; i++) begin
         chk("bp_svalid", 64'(S_AxVALID), 64'd1);
         chk("bp_saddr",  64'(S_AxADDR), 64'h2C00);
         chk("bp_mready", 64'(M_AxREADY), 64'd0);
         chk("bp_idx",    64'(Grant_Idx), 64'd2);
         Txn_Done = (i == 2);
         nxt();
         Txn_Done = 1'b0;
      end
      chk("bp_after_spurious_svalid", 64'(S_AxVALID), 64'd1);
      chk("bp_after_spurious_busy",   64'(Busy), 64'd1);
      S_AxREADY = 1'b1;
      #1;
      chk("bp_accept_mready", 64'(M_AxREADY), 64'b100);
      chk("bp_accept_slen",   64'(S_AxLEN), 64'd7);
      $display("txn backpressure: grant=%0d addr=%h len=%0d", Grant_Idx, S_AxADDR, S_AxLEN);
      nxt();
      M_AxVALID = '0;
      #1;
      chk("bp_wait_mready", 64'(M_AxREADY), 64'd0);
      chk("bp_wait_busy",   64'(Busy), 64'd1);
      Txn_Done = 1'b1;
      nxt();
      Txn_Done  = 1'b0;
      S_AxREADY = 1'b0;

      // Reset while in WAIT_DONE, then a simultaneous 0/1 request
      M_AxVALID = 3'b001;
      S_AxREADY = 1'b1;
      nxt();
      nxt();
      chk("midrst_pre_busy", 64'(Busy), 64'd1);
      #3;
      ARESETN = 1'b0;
      #1;
      chk("midrst_busy",   64'(Busy), 64'd0);
      chk("midrst_oh",     64'(Grant_Onehot), 64'd0);
      chk("midrst_idx",    64'(Grant_Idx), 64'd0);
      chk("midrst_svalid", 64'(S_AxVALID), 64'd0);
      chk("midrst_mready", 64'(M_AxREADY), 64'd0);
      chk("midrst_saddr",  64'(S_AxADDR), 64'd0);
      chk("midrst_slen",   64'(S_AxLEN), 64'd0);
      nxt();
      ARESETN   = 1'b1;
      M_AxVALID = 3'b011;
      S_AxREADY = 1'b0;
      nxt();
      chk("postrst_idx",    64'(Grant_Idx), 64'd0);
      chk("postrst_oh",     64'(Grant_Onehot), 64'b001);
      chk("postrst_svalid", 64'(S_AxVALID), 64'd1);
      $display("txn post-reset: grant=%0d addr=%h", Grant_Idx, S_AxADDR);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axi_addr_rr_arbiter.md
Name: axi_addr_rr_arbiter

Overview:
- Round-robin arbiter that shares one AXI slave address channel (AW or AR) among NUM_M masters.
- It grants one master and muxes that master's address beat onto the slave port.
- It holds the grant until the response phase of that transaction completes, signalled by Txn_Done.
- It sits in the interconnect between the master-side ports and the single slave-side address channel, ahead of the data/response routing logic, which uses Grant_Idx.

Parameters:
- NUM_M, 2, number of requesting masters; legal 2..4.
- ADDR_W, 32, address width.
- LEN_W, 8, burst length (AxLEN) width.
- IDX_W, 2, width of Grant_Idx; must satisfy 2**IDX_W >= NUM_M.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  asynchronous active-low reset.
- M_AxVALID  in  NUM_M  per-master address valid.
- M_AxADDR  in  NUM_M*ADDR_W  per-master address, master i at bits [i*ADDR_W +: ADDR_W].
- M_AxLEN  in  NUM_M*LEN_W  per-master burst length, same packing.
- M_AxREADY  out  NUM_M  per-master address ready.
- S_AxVALID  out  1  slave-side address valid.
- S_AxADDR  out  ADDR_W  slave-side address.
- S_AxLEN  out  LEN_W  slave-side burst length.
- S_AxREADY  in  1  slave-side address ready.
- Txn_Done  in  1  one-cycle pulse when the granted transaction's response handshake completes (BVALID&BREADY, or RVALID&RREADY&RLAST).
- Grant_Idx  out  IDX_W  index of the current owner; valid while Busy=1.
- Grant_Onehot  out  NUM_M  one-hot grant; all zero when idle.
- Busy  out  1  high in ADDR and WAIT_DONE.

Behaviour:
- Reset (async assert, sync release):
  - State = IDLE, Grant_Idx = 0, Grant_Onehot = 0, Busy = 0.
  - last_grant = NUM_M-1, so master 0 has top priority first.
  - All outputs are driven low: M_AxREADY = 0, S_AxVALID = 0, S_AxADDR = 0, S_AxLEN = 0.
- FSM states: IDLE, ADDR, WAIT_DONE.
- IDLE:
  - S_AxVALID = 0, M_AxREADY = 0.
  - If any M_AxVALID bit is set, pick the first requester scanning from last_grant+1 upward, modulo NUM_M.
  - Register the picked index into Grant_Idx and Grant_Onehot, then go to ADDR.
  - Grant latency: request seen at edge t, S_AxVALID high from cycle t+1.
- ADDR:
  - S_AxVALID, S_AxADDR and S_AxLEN are combinational muxes of the granted master's inputs.
  - M_AxREADY[Grant_Idx] = S_AxREADY; all other M_AxREADY bits = 0.
  - On S_AxVALID & S_AxREADY, go to WAIT_DONE.
  - Txn_Done is ignored in ADDR.
  - If the granted master drops VALID before the handshake (an AXI violation), the FSM stays in ADDR and S_AxVALID follows the input.
- WAIT_DONE:
  - S_AxVALID = 0, all M_AxREADY = 0; the S_AxADDR/S_AxLEN mux still follows the granted master.
  - On Txn_Done: last_grant <= Grant_Idx, Grant_Onehot <= 0, Busy <= 0, go to IDLE.
  - There is at least one IDLE cycle between consecutive grants. Back-to-back throughput is therefore one transaction per (grant + addr + response + 1) cycles.
- Fairness: a master that keeps requesting is granted at most once per NUM_M grants while others are requesting.
- No new grant is issued while Busy=1; other masters' VALIDs are held off, with READY = 0.
- Bits of M_AxVALID at index >= NUM_M do not exist; the pointer wraps from NUM_M-1 to 0.
- Simultaneous requests in IDLE resolve by the round-robin order only.
- Reset mid-transaction returns to IDLE immediately. The in-flight transaction is abandoned and Txn_Done is not expected.

Decomposition:
- Shared package axi_ic_pkg:
  - state encoding constants ARB_IDLE = 2'd0, ARB_ADDR = 2'd1, ARB_WAIT = 2'd2;
  - the NUM_M maximum (4).
- One sub-module, rr_priority_picker:
  - purely combinational;
  - inputs: request vector and last_grant;
  - outputs: next index and a found flag.
- Muxing and the FSM stay in the top module.

Test Plan:
- Single request: after reset, M_AxVALID = 2'b10 with ADDR 0x1000 and LEN 3 → Grant_Idx = 1 next cycle, S_AxVALID = 1, S_AxADDR = 0x1000, S_AxLEN = 3. With S_AxREADY = 1, M_AxREADY[1] pulses for one cycle. Txn_Done then returns the FSM to IDLE and Busy = 0.
- Contention fairness: NUM_M = 3, all three VALIDs held, with a 2-cycle slave ready and Txn_Done 4 cycles after each handshake → grant order 0, 1, 2, 0, 1, 2.
- Hold-off: master 0 granted and in WAIT_DONE while master 1 asserts VALID → M_AxREADY[1] stays 0 and Grant_Idx stays 0 until Txn_Done; master 1 is granted the cycle after IDLE.
- Slave backpressure: S_AxREADY low for 5 cycles in ADDR → S_AxVALID stays high and S_AxADDR stays stable; exactly one M_AxREADY pulse on the accept cycle.
- Spurious Txn_Done in ADDR, before the handshake → FSM stays in ADDR and the grant is unchanged.
- Reset mid-transaction: ARESETN low during WAIT_DONE → all outputs go to 0 asynchronously. After release, master 0 wins a simultaneous 0/1 request.
